// File: rtl/hilo_md_unit.sv
// HI/LO multiply/divide unit for the EX stage: fixed-latency multiplier,
// 32-cycle radix-2 restoring divider, MTHI/MTLO, and flush cancellation.
module hilo_md_unit #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        hi_lo_sel,
  output logic [31:0] RHLOut,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_a, r_b, r_quo, r_rem;
  logic [4:0]  r_cnt;
  logic        r_signed, r_neg_q, r_neg_r;

  logic        w_accept, w_mul_last, w_div_last;
  logic        w_rs_neg, w_rt_neg;
  logic [63:0] w_a_ext, w_b_ext, w_prod;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_rem_nxt, w_quo_nxt, w_div_q, w_div_r;

  assign busy       = (r_state != S_IDLE);
  assign RHLOut     = hi_lo_sel ? r_hi : r_lo;
  assign w_accept   = start & ~busy & ~flush;
  assign w_mul_last = (r_cnt == 5'(MUL_LAT - 1));
  assign w_div_last = (r_cnt == 5'd31);

  // Signedness only matters for MULT/DIV (op[0]==0).
  assign w_rs_neg = ~op[0] & rs_data[31];
  assign w_rt_neg = ~op[0] & rt_data[31];

  assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
  assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_rem_nxt = w_ge ? (w_shift[31:0] - r_b) : w_shift[31:0];
  assign w_quo_nxt = {r_quo[30:0], w_ge};
  assign w_div_q   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_div_r   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (op[2:1] == 2'b00)      w_state_nxt = S_MUL;
          else if (op[2:1] == 2'b01) w_state_nxt = S_DIV;
        end
      end
      S_MUL:   if (flush || w_mul_last) w_state_nxt = S_IDLE;
      S_DIV:   if (flush || w_div_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (w_accept) begin
      case (op)
        3'b000, 3'b001: begin
          r_a      <= rs_data;
          r_b      <= rt_data;
          r_signed <= ~op[0];
          r_cnt    <= '0;
        end
        3'b010, 3'b011: begin
          r_a     <= rs_data;
          r_b     <= w_rt_neg ? -rt_data : rt_data;
          r_quo   <= w_rs_neg ? -rs_data : rs_data;
          r_rem   <= '0;
          r_neg_q <= w_rs_neg ^ w_rt_neg;
          r_neg_r <= w_rs_neg;
          r_cnt   <= '0;
        end
        3'b100:  r_hi <= rs_data;
        3'b101:  r_lo <= rs_data;
        default: ;
      endcase
    end else if (r_state == S_MUL && !flush) begin
      r_cnt <= r_cnt + 5'd1;
      if (w_mul_last) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end
    end else if (r_state == S_DIV && !flush) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 5'd1;
      if (w_div_last) begin
        // Divide by zero returns the raw dividend in HI, all-ones in LO.
        if (r_b == '0) begin
          r_hi <= r_a;
          r_lo <= '1;
        end else begin
          r_hi <= w_div_r;
          r_lo <= w_div_q;
        end
      end
    end
  end

endmodule
